// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: word, RAM handshake state, and arbiter state.
// Also holds the word returned to a cache when its transaction ends in error.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam word_t ARB_ERR_WORD = 32'hBAD1BAD1;
endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates icache misses and dcache accesses onto one RAM port.
// Data has priority, instruction starvation is bounded, grants time out.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              err
);

  localparam int DS_W = $clog2(MAX_DSTREAK + 1);
  localparam int TC_W = $clog2(TIMEOUT);

  arb_state_t      state_r, next_s;
  logic [DS_W-1:0] dstreak_r;
  logic [TC_W-1:0] tcount_r;
  logic            err_r;
  logic            dreq_s, starve_s, timeout_s, fail_s;

  assign dreq_s    = dREN | dWEN;
  assign starve_s  = iREN && (dstreak_r == DS_W'(MAX_DSTREAK));
  assign timeout_s = (tcount_r == TC_W'(TIMEOUT - 1));
  assign err       = err_r;

  // Next-state and RAM/cache outputs; the completing cycle is combinational.
  always_comb begin
    next_s   = state_r;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    fail_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (dreq_s && !starve_s) begin
          next_s = DGNT;
        end else if (iREN) begin
          next_s = IGNT;
        end else begin
          next_s = IDLE;
        end
      end
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        // A withdrawn request ends the grant silently, even on ACCESS.
        if (!iREN) begin
          next_s = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait  = 1'b0;
          iload  = ramload;
          next_s = IDLE;
        end else if ((ramstate == ERROR) || timeout_s) begin
          iwait  = 1'b0;
          iload  = WORD_W'(ARB_ERR_WORD);
          fail_s = 1'b1;
          next_s = IDLE;
        end else begin
          next_s = IGNT;
        end
      end
      DGNT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dreq_s) begin
          next_s = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait  = 1'b0;
          dload  = dREN ? ramload : '0;
          next_s = IDLE;
        end else if ((ramstate == ERROR) || timeout_s) begin
          dwait  = 1'b0;
          dload  = WORD_W'(ARB_ERR_WORD);
          fail_s = 1'b1;
          next_s = IDLE;
        end else begin
          next_s = DGNT;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // State, starvation streak, grant timer and sticky error register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      dstreak_r <= '0;
      tcount_r  <= '0;
      err_r     <= 1'b0;
    end else begin
      state_r <= next_s;
      err_r   <= err_r | fail_s;
      if ((state_r != IDLE) && (next_s == state_r)) begin
        tcount_r <= tcount_r + TC_W'(1);
      end else begin
        tcount_r <= '0;
      end
      if ((state_r == IDLE) && (next_s == DGNT)) begin
        if (!iREN) begin
          dstreak_r <= '0;
        end else if (dstreak_r == DS_W'(MAX_DSTREAK)) begin
          dstreak_r <= dstreak_r;
        end else begin
          dstreak_r <= dstreak_r + DS_W'(1);
        end
      end else if ((state_r == IDLE) && (next_s == IGNT)) begin
        dstreak_r <= '0;
      end else begin
        dstreak_r <= dstreak_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected wait pulses into a
// scoreboard; a negedge monitor pops and checks whenever iwait or dwait drops.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  ramstate_t   ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  typedef struct {
    bit          is_i;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  mem_arbiter #(.WORD_W(32), .MAX_DSTREAK(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input bit is_i, input bit chk_data, input logic [31:0] data);
    exp_t e;
    e.is_i = is_i;
    e.chk_data = chk_data;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every wait pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (iwait === 1'b0 || dwait === 1'b0) begin
      if (sb.size() == 0) begin
        tot_cnt++;
        $display("FAIL unexpected_pulse: got iwait=%0b dwait=%0b expected none at %0t",
                 iwait, dwait, $time);
      end else begin
        e = sb.pop_front();
        chk("pulse_owner_i", {31'd0, (iwait === 1'b0)}, {31'd0, e.is_i});
        chk("pulse_not_both", {31'd0, (iwait === 1'b0 && dwait === 1'b0)}, 32'd0);
        if (e.chk_data) begin
          chk(e.is_i ? "iload" : "dload", e.is_i ? iload : dload, e.data);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; iREN = 1'b1; iaddr = 32'h0000_0040;
    dREN = 1'b0; dWEN = 1'b0; daddr = 32'd0; dstore = 32'd0;
    ramload = 32'd0; ramstate = FREE;

    // Reset held for two edges with iREN pending
    step();
    @(negedge CLK);
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk("first_cycle_idle_ramREN", {31'd0, ramREN}, 32'd0);

    // Instruction miss: BUSY, BUSY, ACCESS
    step();
    ramstate = BUSY;
    @(negedge CLK);
    chk("igrant_ramREN", {31'd0, ramREN}, 32'd1);
    chk("igrant_ramaddr0", ramaddr, 32'h0000_0040);
    step();
    @(negedge CLK);
    chk("igrant_ramaddr1", ramaddr, 32'h0000_0040);
    chk("igrant_busy_iwait", {31'd0, iwait}, 32'd1);
    step();
    ramstate = ACCESS; ramload = 32'h2108_0004;
    push(1'b1, 1'b1, 32'h2108_0004);
    @(negedge CLK);
    chk("igrant_ramaddr2", ramaddr, 32'h0000_0040);
    step();
    iREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    chk("after_i_idle", {31'd0, ramREN}, 32'd0);

    // Contention: data write wins, instruction after one IDLE cycle
    iREN = 1'b1; iaddr = 32'h0000_0100;
    dWEN = 1'b1; daddr = 32'h0000_0080; dstore = 32'hDEAD_BEEF;
    step();
    ramstate = ACCESS; ramload = 32'h1234_5678;
    push(1'b0, 1'b0, 32'd0);
    @(negedge CLK);
    chk("cont_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("cont_ramREN", {31'd0, ramREN}, 32'd0);
    chk("cont_ramaddr", ramaddr, 32'h0000_0080);
    chk("cont_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("cont_iwait_held", {31'd0, iwait}, 32'd1);
    step();
    dWEN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    chk("cont_idle_gap", {31'd0, ramREN | ramWEN}, 32'd0);
    step();
    ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    push(1'b1, 1'b1, 32'h0BAD_F00D);
    @(negedge CLK);
    chk("cont_i_ramaddr", ramaddr, 32'h0000_0100);
    step();
    ramstate = FREE;

    // Starvation: four data reads with iREN pending, then forced IGNT
    iaddr = 32'h0000_0200; dREN = 1'b1; daddr = 32'h0000_0300;
    for (int k = 0; k < 4; k++) begin
      step();
      ramstate = ACCESS; ramload = 32'h0000_1000 + k;
      push(1'b0, 1'b1, 32'h0000_1000 + k);
      @(negedge CLK);
      chk("starve_dgrant_addr", ramaddr, 32'h0000_0300 + k);
      step();
      ramstate = FREE; daddr = 32'h0000_0301 + k;
    end
    step();
    ramstate = ACCESS; ramload = 32'h0000_55AA;
    push(1'b1, 1'b1, 32'h0000_55AA);
    @(negedge CLK);
    chk("starve_forced_i_addr", ramaddr, 32'h0000_0200);
    chk("starve_dwait_held", {31'd0, dwait}, 32'd1);
    chk("starve_dstreak_clear", {29'd0, dut.dstreak_r}, 32'd0);
    step();
    iREN = 1'b0; ramstate = FREE;

    // RAM ERROR during a data read
    daddr = 32'h0000_0400;
    step();
    ramstate = ERROR;
    push(1'b0, 1'b1, 32'hBAD1_BAD1);
    @(negedge CLK);
    chk("error_err_not_yet", {31'd0, err}, 32'd0);
    step();
    dREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    chk("error_err_set", {31'd0, err}, 32'd1);
    step(); step();
    @(negedge CLK);
    chk("error_err_sticky", {31'd0, err}, 32'd1);

    // Reset mid-write aborts and clears err
    dWEN = 1'b1; daddr = 32'h0000_0700; dstore = 32'h0000_0001; ramstate = BUSY;
    step();
    @(negedge CLK);
    chk("midrst_ramWEN_before", {31'd0, ramWEN}, 32'd1);
    step();
    RST = 1'b1; dWEN = 1'b0;
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_ramWEN_after", {31'd0, ramWEN}, 32'd0);
    chk("midrst_err_cleared", {31'd0, err}, 32'd0);

    // Timeout: BUSY forever, completes in 64th grant cycle
    iREN = 1'b1; iaddr = 32'h0000_0500; ramstate = BUSY;
    step();
    for (int c = 1; c < 64; c++) begin
      step();
    end
    push(1'b1, 1'b1, 32'hBAD1_BAD1);
    @(negedge CLK);
    chk("timeout_still_granted", {31'd0, ramREN}, 32'd1);
    step();
    iREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    chk("timeout_err", {31'd0, err}, 32'd1);
    chk("timeout_idle", {31'd0, ramREN}, 32'd0);

    // Withdrawal during BUSY
    iREN = 1'b1; iaddr = 32'h0000_0600; ramstate = BUSY;
    step();
    @(negedge CLK);
    chk("wd_granted", {31'd0, ramREN}, 32'd1);
    step();
    iREN = 1'b0;
    @(negedge CLK);
    chk("wd_no_pulse", {31'd0, iwait}, 32'd1);
    step();
    ramstate = FREE;
    @(negedge CLK);
    chk("wd_idle_ramREN", {31'd0, ramREN}, 32'd0);

    step(); step();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and beside the data cache; consumes icache miss requests (iREN/iaddr) and dcache requests (dREN/dWEN/daddr/dstore).
- Arbitrates them onto the single RAM port and returns iwait/iload and dwait/dload.
- Registered FSM: one owner per RAM transaction, data priority, bounded instruction starvation, transaction timeout.

Parameters:
- WORD_W, 32, data/address width.
- MAX_DSTREAK, 4, maximum consecutive data grants while iREN is pending before instruction is forced.
- TIMEOUT, 64, maximum cycles in a grant state before abort with error.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- iREN  in  1  icache read request.
- iaddr  in  WORD_W  icache read address.
- iwait  out  1  low for exactly the completing cycle of an instruction read.
- iload  out  WORD_W  instruction word, valid when iwait=0.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request (dREN and dWEN never both 1).
- daddr  in  WORD_W  dcache address.
- dstore  in  WORD_W  dcache write data.
- dwait  out  1  low for exactly the completing cycle of a data access.
- dload  out  WORD_W  data read word, valid when dwait=0.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- err  out  1  sticky error flag.

Behaviour:
- Reset: one clock, synchronous, active-high, clock CLK. RST=1 at a rising edge gives state=IDLE, dstreak=0, tcount=0, err=0. Reset mid-transaction aborts it; RAM enables drop the cycle after the reset edge.
- Reset values of outputs: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, err=0.
- FSM states are IDLE, IGNT and DGNT.
- IDLE:
  - RAM enables are 0.
  - If (dREN|dWEN) and not (iREN && dstreak==MAX_DSTREAK), go to DGNT.
  - Otherwise, if iREN, go to IGNT.
  - Otherwise stay in IDLE.
- Grant counting: on each DGNT entry, dstreak increments (saturating) if iREN=1, else clears to 0. On each IGNT entry, dstreak clears.
- IGNT:
  - ramREN=1, ramWEN=0, ramaddr=iaddr.
  - When ramstate==ACCESS: iwait=0 and iload=ramload in the same cycle (combinational); next state is IDLE.
- DGNT:
  - ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - When ramstate==ACCESS: dwait=0, dload=ramload (reads); next state is IDLE.
- The non-owner's wait stays 1 throughout.
- Minimum latency from request to wait low is 2 cycles: IDLE→grant edge, then ACCESS. There is always one IDLE cycle between transactions.
- Owner withdrawal: if the owner's request drops before ACCESS, go to IDLE next cycle with no wait pulse. No error.
- ERROR: ramstate==ERROR in a grant state ends the transaction like ACCESS. The owner's wait goes low, its load is 32'hBAD1BAD1, and err is set sticky (cleared only by RST).
- Timeout:
  - tcount clears on grant entry and increments each cycle in a grant state.
  - When tcount==TIMEOUT-1 without ACCESS/ERROR, the transaction completes as ERROR in that cycle.
- Simultaneous events:
  - ACCESS and ERROR are mutually exclusive by encoding.
  - New requests arriving while granted are held until IDLE.
  - Both requesting in IDLE: data wins unless the starvation rule applies.

Decomposition:
- cpu_types_pkg supplies word_t and ramstate_t (FREE/BUSY/ACCESS/ERROR).
- Add the arbiter state enum arb_state_t {IDLE, IGNT, DGNT} and the constant ARB_ERR_WORD=32'hBAD1BAD1 to the same package.
- Single module. The dstreak/tcount counters stay inline; no sub-module is warranted.

Test Plan:
- Reset: RST=1 for 2 cycles with iREN=1 → iwait=1, dwait=1, ramREN=0, err=0. First grant occurs in the 2nd cycle after RST falls.
- Instruction miss: iREN=1, iaddr=0x0000_0040; RAM returns BUSY×2, then ACCESS with ramload=0x2108_0004 → iwait low for exactly 1 cycle with iload=0x2108_0004. ramaddr=0x40 throughout IGNT.
- Contention: iREN and dWEN (daddr=0x80, dstore=0xDEAD_BEEF) both asserted in IDLE → data granted first with ramWEN=1, ramstore=0xDEADBEEF. Instruction is granted after one IDLE cycle.
- Starvation: iREN held, dREN re-asserted every transaction → exactly MAX_DSTREAK=4 data grants, then an IGNT, then dstreak=0.
- Error/timeout:
  - ramstate=ERROR during DGNT read → dwait low 1 cycle, dload=0xBAD1BAD1, err=1 and remains set.
  - Separately, ramstate stuck at BUSY → completes at cycle 64 of the grant with err=1.
- Withdrawal: iREN dropped while IGNT and ramstate=BUSY → IDLE next cycle, no iwait pulse, ramREN=0.
